// File: rtl/uarch_pkg.sv
// Shared microarchitecture types for the writeback / common data bus path.
package uarch_pkg;

    localparam int TAG_WIDTH  = 6;
    localparam int DATA_WIDTH = 32;
    localparam int CDB_PORTS  = 2;

    typedef struct packed {
        logic [TAG_WIDTH-1:0]  tag;
        logic [DATA_WIDTH-1:0] data;
    } writeback_packet_t;

endpackage

// File: rtl/rr_pick2.sv
// Rotating two-pick priority encoder: first and second requesters at or after ptr_i,
// plus the pointer just past the last one picked.
module rr_pick2 #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt0_o,
    output logic [NUM_REQ-1:0] gnt1_o,
    output logic               any_o,
    output logic [PTR_W-1:0]   next_ptr_o
);

    int   idx;
    int   last_idx;
    int   nxt;
    logic found0;
    logic found1;

    always_comb begin
        gnt0_o   = '0;
        gnt1_o   = '0;
        found0   = 1'b0;
        found1   = 1'b0;
        idx      = 0;
        last_idx = int'(ptr_i);
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr_i) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req_i[idx]) begin
                if (!found0) begin
                    gnt0_o[idx] = 1'b1;
                    found0      = 1'b1;
                    last_idx    = idx;
                end else if (!found1) begin
                    gnt1_o[idx] = 1'b1;
                    found1      = 1'b1;
                    last_idx    = idx;
                end
            end
        end
        nxt = last_idx + 1;
        if (nxt >= NUM_REQ) nxt = 0;
        any_o      = found0;
        next_ptr_o = PTR_W'(nxt);
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Two-port common data bus arbiter: round-robin picks up to two writeback requesters
// per cycle and broadcasts their packets one cycle later.
module cdb_arbiter
    import uarch_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush,
    input  logic [NUM_REQ-1:0]                  fu_val,
    input  writeback_packet_t [NUM_REQ-1:0]     fu_pkt,
    output logic [NUM_REQ-1:0]                  fu_rdy,
    output writeback_packet_t                   cdb_port0,
    output writeback_packet_t                   cdb_port1,
    output logic                                cdb_port0_val,
    output logic                                cdb_port1_val
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]                  rr_ptr_q, rr_ptr_d;
    writeback_packet_t [CDB_PORTS-1:0] pkt_q, pkt_d;
    logic [CDB_PORTS-1:0]              val_q, val_d;

    logic [NUM_REQ-1:0] gnt0, gnt1;
    logic               any_gnt;
    logic [PTR_W-1:0]   next_ptr;

    rr_pick2 #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_pick (
        .req_i      (fu_val),
        .ptr_i      (rr_ptr_q),
        .gnt0_o     (gnt0),
        .gnt1_o     (gnt1),
        .any_o      (any_gnt),
        .next_ptr_o (next_ptr)
    );

    // rst gates fu_rdy so no requester sees an accept while the bus is held in reset.
    assign fu_rdy = (gnt0 | gnt1) & {NUM_REQ{~flush & rst}};

    always_comb begin
        pkt_d    = pkt_q;
        val_d[0] = (|gnt0) & ~flush;
        val_d[1] = (|gnt1) & ~flush;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt0[i] && !flush) pkt_d[0] = fu_pkt[i];
            if (gnt1[i] && !flush) pkt_d[1] = fu_pkt[i];
        end
        rr_ptr_d = (any_gnt && !flush) ? next_ptr : rr_ptr_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_q <= '0;
            pkt_q    <= '0;
            val_q    <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            pkt_q    <= pkt_d;
            val_q    <= val_d;
        end
    end

    assign cdb_port0     = pkt_q[0];
    assign cdb_port1     = pkt_q[1];
    assign cdb_port0_val = val_q[0];
    assign cdb_port1_val = val_q[1];

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter (NUM_REQ=4): directed vector table, reset and hold
// sequences, then randomized traffic against a queue-free round-robin reference model.
module tb_cdb_arbiter;
    import uarch_pkg::*;

    localparam int N = 4;

    logic                         clk;
    logic                         rst;
    logic                         flush;
    logic [N-1:0]                 fu_val;
    writeback_packet_t [N-1:0]    fu_pkt;
    logic [N-1:0]                 fu_rdy;
    writeback_packet_t            cdb_port0, cdb_port1;
    logic                         cdb_port0_val, cdb_port1_val;

    cdb_arbiter #(.NUM_REQ(N)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .fu_val        (fu_val),
        .fu_pkt        (fu_pkt),
        .fu_rdy        (fu_rdy),
        .cdb_port0     (cdb_port0),
        .cdb_port1     (cdb_port1),
        .cdb_port0_val (cdb_port0_val),
        .cdb_port1_val (cdb_port1_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int mp      = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference: walk the requesters in priority order from the pointer, take the first two.
    task automatic ref_pick(input logic [N-1:0] v, input int p, output int g0, output int g1);
        int idx;
        g0 = -1;
        g1 = -1;
        for (int k = 0; k < N; k++) begin
            idx = (p + k) % N;
            if (v[idx]) begin
                if (g0 < 0) g0 = idx;
                else if (g1 < 0) g1 = idx;
            end
        end
    endtask

    // Called at posedge+1; returns at the next posedge+1 with model pointer updated.
    task automatic run_cycle(input logic [N-1:0] v, input logic f, output int g0, output int g1);
        logic [N-1:0] exp_rdy;
        fu_val = v;
        flush  = f;
        #1;
        ref_pick(v, mp, g0, g1);
        if (f) begin
            g0 = -1;
            g1 = -1;
        end
        exp_rdy = '0;
        if (g0 >= 0) exp_rdy[g0] = 1'b1;
        if (g1 >= 0) exp_rdy[g1] = 1'b1;
        chk("fu_rdy", 64'(fu_rdy), 64'(exp_rdy));
        @(posedge clk);
        #1;
        chk("val0", 64'(cdb_port0_val), 64'(g0 >= 0));
        chk("val1", 64'(cdb_port1_val), 64'(g1 >= 0));
        if (g0 >= 0) chk("pkt0", 64'(cdb_port0), 64'(fu_pkt[g0]));
        if (g1 >= 0) chk("pkt1", 64'(cdb_port1), 64'(fu_pkt[g1]));
        if (g1 >= 0) mp = (g1 + 1) % N;
        else if (g0 >= 0) mp = (g0 + 1) % N;
        chk("rr_ptr", 64'(dut.rr_ptr_q), 64'(mp));
    endtask

    typedef struct {
        logic [N-1:0] val;
        logic         fl;
        logic [N-1:0] rdy;
        logic         v0;
        int           i0;
        logic         v1;
        int           i1;
        int           ptr;
    } vec_t;

    vec_t tbl[9];
    int   wait_cnt[N];
    logic [N-1:0] pend;

    initial begin
        int g0, g1, worst;

        tbl[0] = '{4'b1111, 1'b0, 4'b0011, 1'b1, 0, 1'b1, 1, 2};
        tbl[1] = '{4'b1111, 1'b0, 4'b1100, 1'b1, 2, 1'b1, 3, 0};
        tbl[2] = '{4'b0010, 1'b0, 4'b0010, 1'b1, 1, 1'b0, 0, 2};
        tbl[3] = '{4'b1001, 1'b0, 4'b1001, 1'b1, 3, 1'b1, 0, 1};
        tbl[4] = '{4'b1000, 1'b0, 4'b1000, 1'b1, 3, 1'b0, 0, 0};
        tbl[5] = '{4'b0110, 1'b1, 4'b0000, 1'b0, 0, 1'b0, 0, 0};
        tbl[6] = '{4'b0110, 1'b0, 4'b0110, 1'b1, 1, 1'b1, 2, 3};
        tbl[7] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 0, 1'b0, 0, 3};
        tbl[8] = '{4'b0101, 1'b0, 4'b0101, 1'b1, 0, 1'b1, 2, 3};

        for (int i = 0; i < N; i++) begin
            fu_pkt[i].tag  = TAG_WIDTH'(8 + i);
            fu_pkt[i].data = 32'hA000_0000 | $urandom_range(0, 32'hFFFF);
        end

        rst    = 1'b0;
        flush  = 1'b0;
        fu_val = 4'b1111;
        #12;
        chk("rst_rdy", 64'(fu_rdy), 64'd0);
        chk("rst_val0", 64'(cdb_port0_val), 64'd0);
        chk("rst_val1", 64'(cdb_port1_val), 64'd0);
        chk("rst_pkt0", 64'(cdb_port0), 64'd0);
        chk("rst_ptr", 64'(dut.rr_ptr_q), 64'd0);
        fu_val = '0;
        rst    = 1'b1;
        @(posedge clk);
        #1;

        for (int t = 0; t < 9; t++) begin
            fu_val = tbl[t].val;
            flush  = tbl[t].fl;
            #1;
            chk($sformatf("tbl%0d_rdy", t), 64'(fu_rdy), 64'(tbl[t].rdy));
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_val0", t), 64'(cdb_port0_val), 64'(tbl[t].v0));
            chk($sformatf("tbl%0d_val1", t), 64'(cdb_port1_val), 64'(tbl[t].v1));
            if (tbl[t].v0) chk($sformatf("tbl%0d_pkt0", t), 64'(cdb_port0), 64'(fu_pkt[tbl[t].i0]));
            if (tbl[t].v1) chk($sformatf("tbl%0d_pkt1", t), 64'(cdb_port1), 64'(fu_pkt[tbl[t].i1]));
            chk($sformatf("tbl%0d_ptr", t), 64'(dut.rr_ptr_q), 64'(tbl[t].ptr));
        end
        mp = 3;

        // Idle cycle: valids drop, packet fields keep the last broadcast.
        run_cycle(4'b0000, 1'b0, g0, g1);
        chk("hold_pkt0", 64'(cdb_port0), 64'(fu_pkt[0]));
        chk("hold_pkt1", 64'(cdb_port1), 64'(fu_pkt[2]));

        // Reset mid-broadcast drops the valids immediately.
        run_cycle(4'b1111, 1'b0, g0, g1);
        chk("pre_rst_val0", 64'(cdb_port0_val), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_val0", 64'(cdb_port0_val), 64'd0);
        chk("mid_rst_val1", 64'(cdb_port1_val), 64'd0);
        chk("mid_rst_pkt0", 64'(cdb_port0), 64'd0);
        chk("mid_rst_ptr", 64'(dut.rr_ptr_q), 64'd0);
        chk("mid_rst_rdy", 64'(fu_rdy), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        mp  = 0;
        @(posedge clk);
        #1;
        chk("post_rst_val0", 64'(cdb_port0_val), 64'd1);
        chk("post_rst_pkt0", 64'(cdb_port0), 64'(fu_pkt[0]));
        chk("post_rst_pkt1", 64'(cdb_port1), 64'(fu_pkt[1]));
        chk("post_rst_ptr", 64'(dut.rr_ptr_q), 64'd2);
        mp = 2;

        // Random traffic: requesters hold their packet until accepted.
        pend = '0;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        for (int c = 0; c < 10000; c++) begin
            logic f;
            f = ($urandom_range(0, 19) == 0);
            run_cycle(pend, f, g0, g1);
            worst = 0;
            for (int i = 0; i < N; i++) begin
                if (pend[i]) begin
                    if (i == g0 || i == g1) begin
                        pend[i]     = 1'b0;
                        wait_cnt[i] = 0;
                    end else if (!f) begin
                        wait_cnt[i]++;
                    end
                    if (wait_cnt[i] > worst) worst = wait_cnt[i];
                end
            end
            chk("starve", 64'(worst > 1), 64'd0);
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i]        = 1'b1;
                    fu_pkt[i].tag  = TAG_WIDTH'($urandom_range(0, 63));
                    fu_pkt[i].data = $urandom;
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
